// File: rtl/cdb_broadcaster_pkg.sv
// rtl/cdb_broadcaster_pkg.sv - shared tag constants for the common-data-bus broadcaster
package cdb_broadcaster_pkg;

   localparam int CDB_LW  = 4;
   localparam int NOLABEL = 0;

   typedef logic [CDB_LW-1:0] tag_t;

   // Source queue tags handed out by the reservation-station queues.
   localparam tag_t QUE_ALU = 4'd1;
   localparam tag_t QUE_MUL = 4'd2;
   localparam tag_t QUE_LD  = 4'd3;
   localparam tag_t QUE_ST  = 4'd4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_pick.sv
// rtl/cdb_broadcaster_rr_pick.sv - combinational round-robin picker, search starts after last
module rr_pick
   import cdb_broadcaster_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] p;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      p   = '0;
      // Offsets 1..N visit every slot once, ending on last itself.
      for (int k = 1; k <= N; k++) begin
         p = IW'((int'(last) + k) % N);
         if (!any && req[p]) begin
            any    = 1'b1;
            idx    = p;
            gnt[p] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_broadcaster.sv
// rtl/cdb_broadcaster.sv - per-source result slots, round-robin CDB arbitration, registered broadcast
module cdb_broadcaster
   import cdb_broadcaster_pkg::*;
#(
   parameter int NSRC = 4,
   parameter int DW   = 32,
   parameter int LW   = CDB_LW
) (
   input  logic               clk,
   input  logic               nRST,
   input  logic [NSRC-1:0]    fuValid,
   input  logic [NSRC*LW-1:0] fuLabel,
   input  logic [NSRC*DW-1:0] fuData,
   output logic [NSRC-1:0]    fuAck,
   output logic               BCEN,
   output logic [LW-1:0]      BClabel,
   output logic [DW-1:0]      BCdata,
   output logic [NSRC-1:0]    pending
);

   localparam int IW = idx_width(NSRC);

   logic [NSRC-1:0] slot_busy;
   logic [LW-1:0]   slot_label [NSRC];
   logic [DW-1:0]   slot_data  [NSRC];
   logic [LW-1:0]   fu_lbl     [NSRC];
   logic [DW-1:0]   fu_dat     [NSRC];

   logic [IW-1:0]   last_grant;
   logic [NSRC-1:0] grant;
   logic [IW-1:0]   grant_idx;
   logic            grant_any;

   for (genvar i = 0; i < NSRC; i++) begin : g_unpack
      assign fu_lbl[i] = fuLabel[i*LW +: LW];
      assign fu_dat[i] = fuData[i*DW +: DW];
   end

   rr_pick #(
      .N  (NSRC),
      .IW (IW)
   ) u_pick (
      .req  (slot_busy),
      .last (last_grant),
      .gnt  (grant),
      .idx  (grant_idx),
      .any  (grant_any)
   );

   // Ack depends only on slot state, never on fuValid.
   assign fuAck   = ~slot_busy | grant;
   assign pending = slot_busy;

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         slot_busy <= '0;
         for (int i = 0; i < NSRC; i++) begin
            slot_label[i] <= '0;
            slot_data[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < NSRC; i++) begin
            // A refill at the grant edge wins over the clear.
            if (fuValid[i] && fuAck[i]) begin
               if (fu_lbl[i] != LW'(NOLABEL)) begin
                  slot_busy[i]  <= 1'b1;
                  slot_label[i] <= fu_lbl[i];
                  slot_data[i]  <= fu_dat[i];
               end else begin
                  slot_busy[i]  <= 1'b0;
               end
            end else if (grant[i]) begin
               slot_busy[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         last_grant <= IW'(NSRC - 1);
         BCEN       <= 1'b0;
         BClabel    <= '0;
         BCdata     <= '0;
      end else if (grant_any) begin
         last_grant <= grant_idx;
         BCEN       <= 1'b1;
         BClabel    <= slot_label[grant_idx];
         BCdata     <= slot_data[grant_idx];
      end else begin
         BCEN       <= 1'b0;
         BClabel    <= '0;
         BCdata     <= '0;
      end
   end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb/tb_cdb_broadcaster.sv - directed self-checking bench for cdb_broadcaster
module tb_cdb_broadcaster;

   localparam int NSRC = 4;
   localparam int DW   = 32;
   localparam int LW   = 4;

   logic               clk = 1'b0;
   logic               nRST = 1'b0;
   logic [NSRC-1:0]    fuValid = '0;
   logic [NSRC*LW-1:0] fuLabel = '0;
   logic [NSRC*DW-1:0] fuData = '0;
   logic [NSRC-1:0]    fuAck;
   logic               BCEN;
   logic [LW-1:0]      BClabel;
   logic [DW-1:0]      BCdata;
   logic [NSRC-1:0]    pending;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cdb_broadcaster #(.NSRC(NSRC), .DW(DW), .LW(LW)) dut (
      .clk     (clk),
      .nRST    (nRST),
      .fuValid (fuValid),
      .fuLabel (fuLabel),
      .fuData  (fuData),
      .fuAck   (fuAck),
      .BCEN    (BCEN),
      .BClabel (BClabel),
      .BCdata  (BCdata),
      .pending (pending)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input int s, input logic [LW-1:0] l, input logic [DW-1:0] d);
      fuValid[s]         = 1'b1;
      fuLabel[s*LW +: LW] = l;
      fuData[s*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      fuValid = '0;
      nRST    = 1'b0;
      step();
      step();
      nRST    = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL reset_bcen: got %b expected 0", BCEN); end
      checks++; if (BClabel !== '0) begin errors++; $display("FAIL reset_label: got %h expected 0", BClabel); end
      checks++; if (BCdata !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", BCdata); end
      checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
      checks++; if (fuAck !== 4'b1111) begin errors++; $display("FAIL reset_ack: got %b expected 1111", fuAck); end
   endtask

   task automatic test_single();
      do_reset();
      offer(2, 4'd5, 32'hDEAD_BEEF);
      #1;
      checks++; if (fuAck[2] !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", fuAck[2]); end
      step();
      fuValid = '0;
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL single_early: got %b expected 0", BCEN); end
      checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_pending: got %b expected 0100", pending); end
      step();
      checks++; if ({BCEN, BClabel, BCdata} !== {1'b1, 4'd5, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL single_bc: got %b/%h/%h expected 1/5/deadbeef", BCEN, BClabel, BCdata);
      end
      step();
      checks++; if ({BCEN, BClabel, BCdata} !== {1'b0, 4'd0, 32'd0}) begin
         errors++; $display("FAIL single_idle: got %b/%h/%h expected 0/0/0", BCEN, BClabel, BCdata);
      end
   endtask

   task automatic test_contention();
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         for (int s = 0; s < 4; s++) offer(s, 4'(s + 1), 32'hA0 + 32'(rep * 16 + s));
         #1;
         checks++; if (fuAck !== 4'b1111) begin errors++; $display("FAIL cont_ack%0d: got %b expected 1111", rep, fuAck); end
         step();
         fuValid = '0;
         checks++; if (pending !== 4'b1111) begin errors++; $display("FAIL cont_pending%0d: got %b expected 1111", rep, pending); end
         for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({BCEN, BClabel, BCdata} !== {1'b1, 4'(k + 1), 32'hA0 + 32'(rep * 16 + k)}) begin
               errors++;
               $display("FAIL cont_order%0d_%0d: got %b/%h/%h expected 1/%h/%h", rep, k, BCEN, BClabel, BCdata,
                        k + 1, 32'hA0 + rep * 16 + k);
            end
         end
         step();
         checks++; if (BCEN !== 1'b0 || pending !== 4'b0000) begin
            errors++; $display("FAIL cont_drain%0d: got bcen=%b pending=%b expected 0/0000", rep, BCEN, pending);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] sb [3][$];
      int seq [3];
      logic [3:0] acc;
      logic [3:0] exp_ack;
      int s;
      do_reset();
      for (int i = 0; i < 3; i++) seq[i] = 0;
      for (int c = 0; c <= 12; c++) begin
         for (int i = 0; i < 3; i++) offer(i, 4'(i + 1), 32'h100 * 32'(i) + 32'(seq[i]));
         #1;
         exp_ack = (c == 0) ? 4'b1111 : (4'b1000 | (4'b0001 << ((c - 1) % 3)));
         checks++; if (fuAck !== exp_ack) begin errors++; $display("FAIL b2b_ack_c%0d: got %b expected %b", c, fuAck, exp_ack); end
         acc = fuValid & fuAck;
         step();
         for (int i = 0; i < 3; i++) if (acc[i]) begin
            sb[i].push_back(32'h100 * 32'(i) + 32'(seq[i]));
            seq[i]++;
         end
         if (c >= 1) begin
            s = (c - 1) % 3;
            checks++;
            if ({BCEN, BClabel, BCdata} !== {1'b1, 4'(s + 1), 32'h100 * 32'(s) + 32'((c - 1) / 3)}) begin
               errors++;
               $display("FAIL b2b_bc_c%0d: got %b/%h/%h expected 1/%h/%h", c, BCEN, BClabel, BCdata,
                        s + 1, 32'h100 * s + (c - 1) / 3);
            end
            if (BCEN === 1'b1 && BClabel >= 4'd1 && BClabel <= 4'd3 && sb[int'(BClabel) - 1].size() > 0) begin
               checks++;
               if (BCdata !== sb[int'(BClabel) - 1][0]) begin
                  errors++; $display("FAIL b2b_sb_c%0d: got %h expected %h", c, BCdata, sb[int'(BClabel) - 1][0]);
               end
               void'(sb[int'(BClabel) - 1].pop_front());
            end else begin
               checks++; errors++;
               $display("FAIL b2b_sb_c%0d: got bcen=%b label=%h expected a held result", c, BCEN, BClabel);
            end
         end
      end
      fuValid = '0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (sb[i].size() != 1) begin errors++; $display("FAIL b2b_left%0d: got %0d expected 1", i, sb[i].size()); end
      end
   endtask

   task automatic test_tag0();
      do_reset();
      offer(3, 4'd0, 32'd7);
      #1;
      checks++; if (fuAck[3] !== 1'b1) begin errors++; $display("FAIL tag0_ack: got %b expected 1", fuAck[3]); end
      step();
      fuValid = '0;
      checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL tag0_pending: got %b expected 0", pending[3]); end
      for (int k = 0; k < 2; k++) begin
         step();
         checks++; if (BCEN !== 1'b0 || BCdata !== '0) begin
            errors++; $display("FAIL tag0_bc%0d: got %b/%h expected 0/0", k, BCEN, BCdata);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      offer(0, 4'd9, 32'h1234);
      offer(1, 4'd10, 32'h5678);
      step();
      fuValid = '0;
      step();
      checks++; if (BCEN !== 1'b1 || pending !== 4'b0010) begin
         errors++; $display("FAIL mid_pre: got bcen=%b pending=%b expected 1/0010", BCEN, pending);
      end
      #2;
      nRST = 1'b0;
      #1;
      checks++; if ({BCEN, BClabel, BCdata} !== {1'b0, 4'd0, 32'd0}) begin
         errors++; $display("FAIL mid_bc: got %b/%h/%h expected 0/0/0", BCEN, BClabel, BCdata);
      end
      checks++; if (pending !== 4'b0000 || fuAck !== 4'b1111) begin
         errors++; $display("FAIL mid_slots: got pending=%b ack=%b expected 0000/1111", pending, fuAck);
      end
      step();
      nRST = 1'b1;
      step();
      checks++; if (BCEN !== 1'b0) begin errors++; $display("FAIL mid_after: got %b expected 0", BCEN); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_tag0();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
